tm_mq_linked_list: RTL and testbench

Parametrised multi-queue linked-list descriptor buffer for the traffic manager. It holds up to DEPTH packet descriptors shared among NQ first-level queues, with per-queue FIFO ordering kept by a next-pointer RAM. Admission control uses a dynamic alpha threshold on free cells. It sits between the classifier/enqueue path and the scheduler dequeue path and provides per-queue depth, which the current fixed-size manager lacks.

---
 rtl/tm_mq_linked_list_pkg.sv | 15 +
 rtl/tm_mq_linked_list_freeq.sv | 38 +++
 rtl/tm_mq_linked_list_ram.sv | 25 ++
 rtl/tm_mq_linked_list.sv | 196 +++++++++++++++++++
 tb/tb_tm_mq_linked_list.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tm_mq_linked_list_pkg.sv
// Shared configuration, descriptor type and FSM states for the multi-queue linked-list buffer.
package tm_mq_linked_list_pkg;

  localparam int unsigned TM_MQ_CFG_NQ    = 32;
  localparam int unsigned TM_MQ_CFG_DEPTH = 256;
  localparam int unsigned TM_MQ_CFG_DW    = 64;

  typedef logic [TM_MQ_CFG_DW-1:0] sch_pkt_desc_type;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } tm_mq_state_e;

endpackage

// File: rtl/tm_mq_linked_list_freeq.sv
// Free-cell FIFO: DEPTH entries of cell indices with first-word fall-through and occupancy count.
module tm_cell_freeq #(
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] rd_data_c,
  output logic [AW:0]   count
);

  logic [AW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign rd_data_c = mem[rd_ptr];

  // pointers wrap modulo DEPTH; callers never push when full or pop when empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/tm_mq_linked_list_ram.sv
// Simple dual-port RAM, synchronous read, write data forwarded on a same-address read.
module ram_1r1w #(
  parameter  int unsigned W  = 8,
  parameter  int unsigned D  = 256,
  localparam int unsigned AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [D];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/tm_mq_linked_list.sv
// Multi-queue linked-list descriptor buffer with shared cells and alpha-threshold admission.
module tm_mq_linked_list
  import tm_mq_linked_list_pkg::*;
#(
  parameter  int unsigned NQ    = TM_MQ_CFG_NQ,
  parameter  int unsigned DEPTH = TM_MQ_CFG_DEPTH,
  parameter  int unsigned DW    = TM_MQ_CFG_DW,
  localparam int unsigned QW    = $clog2(NQ),
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    alpha,
  output logic          enq_ready,
  input  logic          enq_req,
  input  logic [QW-1:0] enq_qid,
  input  logic [DW-1:0] enq_desc,
  output logic          enq_ack,
  output logic          enq_drop,
  output logic          deq_ready,
  input  logic          deq_req,
  input  logic [QW-1:0] deq_qid,
  output logic          deq_ack,
  output logic          deq_empty,
  output logic [QW-1:0] deq_ack_qid,
  output logic [DW-1:0] deq_desc,
  input  logic [QW-1:0] depth_qid,
  output logic [AW:0]   depth,
  output logic [AW:0]   free_count,
  output logic [AW:0]   queue_threshold
);

  localparam int unsigned TW = AW + 9;  // holds free_count << 7 before saturation

  tm_mq_state_e  state_q, state_d;
  logic [AW-1:0] init_cnt;
  logic [AW-1:0] head_q [NQ];
  logic [AW-1:0] head_d [NQ];
  logic [AW-1:0] tail_q [NQ];
  logic [AW-1:0] tail_d [NQ];
  logic [AW:0]   depth_q [NQ];
  logic [AW:0]   depth_d [NQ];

  logic          enq_acc, enq_ok, deq_acc;
  logic [AW:0]   enq_eff;
  logic          s1_valid, s1_empty;
  logic [QW-1:0] s1_qid;
  logic [AW-1:0] s1_cell;

  logic          fq_push, fq_pop;
  logic [AW-1:0] fq_push_data, fq_rd_data;
  logic [AW:0]   fq_count;

  logic          next_we, desc_we;
  logic [AW-1:0] next_waddr, next_wdata, next_rdata, rd_addr;
  logic [DW-1:0] desc_rdata;

  logic [AW:0]   free_nxt, thr_d;
  logic [TW-1:0] thr_wide;

  tm_cell_freeq #(.DEPTH(DEPTH)) u_freeq (
    .clk       (clk),
    .rst       (rst),
    .push      (fq_push),
    .push_data (fq_push_data),
    .pop       (fq_pop),
    .rd_data_c (fq_rd_data),
    .count     (fq_count)
  );

  ram_1r1w #(.W(AW), .D(DEPTH)) u_next_ram (
    .clk   (clk),
    .we    (next_we),
    .waddr (next_waddr),
    .wdata (next_wdata),
    .raddr (rd_addr),
    .rdata (next_rdata)
  );

  ram_1r1w #(.W(DW), .D(DEPTH)) u_desc_ram (
    .clk   (clk),
    .we    (desc_we),
    .waddr (fq_rd_data),
    .wdata (enq_desc),
    .raddr (rd_addr),
    .rdata (desc_rdata)
  );

  assign free_count = fq_count;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // next state, list update and admission; the dequeue retire stage runs before the enqueue
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    depth_d      = depth_q;
    fq_push      = 1'b0;
    fq_push_data = '0;
    fq_pop       = 1'b0;
    next_we      = 1'b0;
    next_waddr   = '0;
    next_wdata   = '0;
    desc_we      = 1'b0;
    enq_ok       = 1'b0;
    enq_eff      = '0;
    enq_acc      = enq_req && enq_ready;
    deq_acc      = deq_req && deq_ready;
    rd_addr      = head_q[deq_qid];

    case (state_q)
      ST_INIT: begin
        fq_push      = 1'b1;
        fq_push_data = init_cnt;
        depth_d      = '{default: '0};
        if (init_cnt == AW'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (s1_valid && !s1_empty) begin
          depth_d[s1_qid] = depth_q[s1_qid] - (AW+1)'(1);
          if (depth_q[s1_qid] != (AW+1)'(1)) head_d[s1_qid] = next_rdata;
          fq_push      = 1'b1;
          fq_push_data = s1_cell;
        end
        if (enq_acc && (fq_count != '0) && (depth_q[enq_qid] < queue_threshold)) begin
          enq_ok  = 1'b1;
          fq_pop  = 1'b1;
          desc_we = 1'b1;
          // a queue just emptied by the retire stage takes the new cell as head
          enq_eff = depth_d[enq_qid];
          if (enq_eff == '0) begin
            head_d[enq_qid] = fq_rd_data;
          end else begin
            next_we    = 1'b1;
            next_waddr = tail_q[enq_qid];
            next_wdata = fq_rd_data;
          end
          tail_d[enq_qid]  = fq_rd_data;
          depth_d[enq_qid] = enq_eff + (AW+1)'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase

    free_nxt = fq_count + (AW+1)'(fq_push) - (AW+1)'(fq_pop);
    thr_wide = alpha[3] ? (TW'(free_nxt) >> alpha[2:0]) : (TW'(free_nxt) << alpha[2:0]);
    thr_d    = (thr_wide > TW'(DEPTH)) ? (AW+1)'(DEPTH) : thr_wide[AW:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt        <= '0;
      head_q          <= '{default: '0};
      tail_q          <= '{default: '0};
      depth_q         <= '{default: '0};
      s1_valid        <= 1'b0;
      s1_empty        <= 1'b0;
      s1_qid          <= '0;
      s1_cell         <= '0;
      enq_ready       <= 1'b0;
      deq_ready       <= 1'b0;
      enq_ack         <= 1'b0;
      enq_drop        <= 1'b0;
      deq_ack         <= 1'b0;
      deq_empty       <= 1'b0;
      deq_ack_qid     <= '0;
      deq_desc        <= '0;
      depth           <= '0;
      queue_threshold <= '0;
    end else begin
      if (state_q == ST_INIT) init_cnt <= init_cnt + AW'(1);
      head_q          <= head_d;
      tail_q          <= tail_d;
      depth_q         <= depth_d;
      s1_valid        <= deq_acc;
      s1_empty        <= (depth_q[deq_qid] == '0);
      s1_qid          <= deq_qid;
      s1_cell         <= head_q[deq_qid];
      enq_ready       <= (state_d == ST_RUN);
      deq_ready       <= (state_d == ST_RUN) && !deq_acc;
      enq_ack         <= enq_ok;
      enq_drop        <= enq_acc && !enq_ok;
      deq_ack         <= s1_valid && !s1_empty;
      deq_empty       <= s1_valid && s1_empty;
      if (s1_valid) deq_ack_qid <= s1_qid;
      if (s1_valid && !s1_empty) deq_desc <= desc_rdata;
      depth           <= depth_d[depth_qid];
      queue_threshold <= thr_d;
    end
  end

endmodule

// File: tb/tb_tm_mq_linked_list.sv
// Directed self-checking bench for tm_mq_linked_list.
module tb_tm_mq_linked_list;
  import tm_mq_linked_list_pkg::*;

  localparam int unsigned QW = 5;
  localparam int unsigned AW = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       alpha = 4'd0;
  logic             enq_ready, enq_ack, enq_drop;
  logic             enq_req = 1'b0;
  logic [QW-1:0]    enq_qid = '0;
  sch_pkt_desc_type enq_desc = '0;
  logic             deq_ready, deq_ack, deq_empty;
  logic             deq_req = 1'b0;
  logic [QW-1:0]    deq_qid = '0;
  logic [QW-1:0]    deq_ack_qid;
  sch_pkt_desc_type deq_desc;
  logic [QW-1:0]    depth_qid = '0;
  logic [AW:0]      depth, free_count, queue_threshold;

  int total = 0;
  int bad   = 0;

  tm_mq_linked_list dut (
    .clk             (clk),
    .rst             (rst),
    .alpha           (alpha),
    .enq_ready       (enq_ready),
    .enq_req         (enq_req),
    .enq_qid         (enq_qid),
    .enq_desc        (enq_desc),
    .enq_ack         (enq_ack),
    .enq_drop        (enq_drop),
    .deq_ready       (deq_ready),
    .deq_req         (deq_req),
    .deq_qid         (deq_qid),
    .deq_ack         (deq_ack),
    .deq_empty       (deq_empty),
    .deq_ack_qid     (deq_ack_qid),
    .deq_desc        (deq_desc),
    .depth_qid       (depth_qid),
    .depth           (depth),
    .free_count      (free_count),
    .queue_threshold (queue_threshold)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // stimulus only: hold reset, release it, wait (bounded) for enq_ready
  task automatic do_reset(output int cyc, output bit saw_ack);
    cyc = -1;
    saw_ack = 1'b0;
    rst = 1'b1; enq_req = 1'b0; deq_req = 1'b0;
    @(negedge clk);
    if (deq_ack) saw_ack = 1'b1;
    @(negedge clk);
    if (deq_ack) saw_ack = 1'b1;
    rst = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (deq_ack) saw_ack = 1'b1;
      if (enq_ready) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cyc; bit saw;
    @(negedge clk); @(negedge clk);
    total++;
    if ({enq_ready, deq_ready, enq_ack, enq_drop, deq_ack, deq_empty} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=000000",
                      {enq_ready, deq_ready, enq_ack, enq_drop, deq_ack, deq_empty});
    end
    total++;
    if (deq_ack_qid !== '0 || deq_desc !== '0) begin
      bad++; $display("FAIL reset_deq_out qid=%0d desc=%h want 0/0", deq_ack_qid, deq_desc);
    end
    total++;
    if (depth !== '0 || free_count !== '0 || queue_threshold !== '0) begin
      bad++; $display("FAIL reset_counts depth=%0d free=%0d thr=%0d want 0/0/0",
                      depth, free_count, queue_threshold);
    end
    do_reset(cyc, saw);
    total++;
    if (cyc != 256) begin bad++; $display("FAIL init_latency got=%0d want=256", cyc); end
    total++;
    if (free_count !== 9'd256 || deq_ready !== 1'b1 || queue_threshold !== 9'd256) begin
      bad++; $display("FAIL init_run free=%0d deq_ready=%b thr=%0d want 256/1/256",
                      free_count, deq_ready, queue_threshold);
    end
    for (int q = 0; q < 32; q++) begin
      depth_qid = QW'(q);
      @(negedge clk);
      total++;
      if (depth !== '0) begin bad++; $display("FAIL init_depth q=%0d got=%0d want=0", q, depth); end
    end
  endtask

  task automatic test_fill_threshold();
    logic exp_ack;
    alpha = 4'd0; depth_qid = 5'd3;
    for (int i = 0; i < 129; i++) begin
      enq_req = 1'b1; enq_qid = 5'd3; enq_desc = 64'h3000 + 64'(i);
      @(negedge clk);
      exp_ack = (i < 128);
      total++;
      if (enq_ack !== exp_ack || enq_drop !== !exp_ack) begin
        bad++; $display("FAIL fill_ack i=%0d ack=%b drop=%b want ack=%b", i, enq_ack, enq_drop, exp_ack);
      end
    end
    enq_req = 1'b0;
    @(negedge clk);
    total++;
    if (depth !== 9'd128 || free_count !== 9'd128 || queue_threshold !== 9'd128) begin
      bad++; $display("FAIL fill_state depth=%0d free=%0d thr=%0d want 128/128/128",
                      depth, free_count, queue_threshold);
    end
    alpha = 4'b1001; @(negedge clk);
    total++;
    if (queue_threshold !== 9'd64) begin bad++; $display("FAIL thr_rshift1 got=%0d want=64", queue_threshold); end
    alpha = 4'b0010; @(negedge clk);
    total++;
    if (queue_threshold !== 9'd256) begin bad++; $display("FAIL thr_saturate got=%0d want=256", queue_threshold); end
    enq_req = 1'b1; enq_qid = 5'd3; enq_desc = 64'h3999;
    @(negedge clk);
    enq_req = 1'b0;
    total++;
    if (enq_ack !== 1'b1 || enq_drop !== 1'b0) begin
      bad++; $display("FAIL thr_admit ack=%b drop=%b want 1/0", enq_ack, enq_drop);
    end
    alpha = 4'b1000; @(negedge clk);
    total++;
    if (depth !== 9'd129 || free_count !== 9'd127 || queue_threshold !== 9'd127) begin
      bad++; $display("FAIL thr_after depth=%0d free=%0d thr=%0d want 129/127/127",
                      depth, free_count, queue_threshold);
    end
    enq_req = 1'b1; enq_qid = 5'd3;
    @(negedge clk);
    enq_req = 1'b0;
    total++;
    if (enq_ack !== 1'b0 || enq_drop !== 1'b1) begin
      bad++; $display("FAIL thr_drop ack=%b drop=%b want 0/1", enq_ack, enq_drop);
    end
  endtask

  task automatic test_ordering();
    int cyc; bit saw;
    sch_pkt_desc_type d [3];
    d[0] = 64'hD1D1_0000_0000_0001;
    d[1] = 64'hD2D2_0000_0000_0002;
    d[2] = 64'hD3D3_0000_0000_0003;
    do_reset(cyc, saw);
    total++;
    if (cyc != 256) begin bad++; $display("FAIL order_init got=%0d want=256", cyc); end
    alpha = 4'd0;
    for (int i = 0; i < 3; i++) begin
      enq_req = 1'b1; enq_qid = 5'd5; enq_desc = d[i];
      @(negedge clk);
    end
    enq_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      deq_req = 1'b1; deq_qid = 5'd5;
      @(negedge clk);
      deq_req = 1'b0;
      total++;
      if (deq_ready !== 1'b0 || deq_ack !== 1'b0) begin
        bad++; $display("FAIL order_gap k=%0d ready=%b ack=%b want 0/0", k, deq_ready, deq_ack);
      end
      @(negedge clk);
      total++;
      if (deq_ack !== 1'b1 || deq_empty !== 1'b0 || deq_ack_qid !== 5'd5 || deq_desc !== d[k]) begin
        bad++; $display("FAIL order_deq k=%0d ack=%b empty=%b qid=%0d desc=%h want 1/0/5/%h",
                        k, deq_ack, deq_empty, deq_ack_qid, deq_desc, d[k]);
      end
    end
    deq_req = 1'b1; deq_qid = 5'd12;
    @(negedge clk); deq_req = 1'b0; @(negedge clk);
    total++;
    if (deq_empty !== 1'b1 || deq_ack_qid !== 5'd12) begin
      bad++; $display("FAIL empty_q12 empty=%b qid=%0d want 1/12", deq_empty, deq_ack_qid);
    end
    deq_req = 1'b1; deq_qid = 5'd5;
    @(negedge clk); deq_req = 1'b0; @(negedge clk);
    total++;
    if (deq_empty !== 1'b1 || deq_ack !== 1'b0 || deq_ack_qid !== 5'd5) begin
      bad++; $display("FAIL empty_q5 empty=%b ack=%b qid=%0d want 1/0/5", deq_empty, deq_ack, deq_ack_qid);
    end
    depth_qid = 5'd5;
    @(negedge clk);
    total++;
    if (depth !== '0 || free_count !== 9'd256) begin
      bad++; $display("FAIL order_final depth=%0d free=%0d want 0/256", depth, free_count);
    end
  endtask

  task automatic test_same_cycle();
    enq_req = 1'b1; enq_qid = 5'd7; enq_desc = 64'hAAAA;
    @(negedge clk);
    enq_desc = 64'hBBBB; deq_req = 1'b1; deq_qid = 5'd7;
    @(negedge clk);
    enq_req = 1'b0; deq_req = 1'b0;
    total++;
    if (enq_ack !== 1'b1) begin bad++; $display("FAIL same_enq ack=%b want 1", enq_ack); end
    @(negedge clk);
    total++;
    if (deq_ack !== 1'b1 || deq_desc !== 64'hAAAA) begin
      bad++; $display("FAIL same_deq ack=%b desc=%h want 1/aaaa", deq_ack, deq_desc);
    end
    depth_qid = 5'd7;
    @(negedge clk);
    total++;
    if (depth !== 9'd1) begin bad++; $display("FAIL same_depth got=%0d want=1", depth); end
    deq_req = 1'b1; deq_qid = 5'd7;
    @(negedge clk); deq_req = 1'b0; @(negedge clk);
    total++;
    if (deq_ack !== 1'b1 || deq_desc !== 64'hBBBB) begin
      bad++; $display("FAIL same_head ack=%b desc=%h want 1/bbbb", deq_ack, deq_desc);
    end
    // dequeue retires in the same cycle a new cell lands on the last-cell queue
    enq_req = 1'b1; enq_qid = 5'd9; enq_desc = 64'hCCCC;
    @(negedge clk);
    enq_req = 1'b0; deq_req = 1'b1; deq_qid = 5'd9;
    @(negedge clk);
    deq_req = 1'b0; enq_req = 1'b1; enq_qid = 5'd9; enq_desc = 64'hDDDD;
    @(negedge clk);
    enq_req = 1'b0; depth_qid = 5'd9;
    total++;
    if (deq_ack !== 1'b1 || deq_desc !== 64'hCCCC || enq_ack !== 1'b1) begin
      bad++; $display("FAIL retire_enq deq_ack=%b desc=%h enq_ack=%b want 1/cccc/1", deq_ack, deq_desc, enq_ack);
    end
    @(negedge clk);
    total++;
    if (depth !== 9'd1) begin bad++; $display("FAIL retire_depth got=%0d want=1", depth); end
    deq_req = 1'b1; deq_qid = 5'd9;
    @(negedge clk); deq_req = 1'b0; @(negedge clk);
    total++;
    if (deq_ack !== 1'b1 || deq_desc !== 64'hDDDD) begin
      bad++; $display("FAIL retire_head ack=%b desc=%h want 1/dddd", deq_ack, deq_desc);
    end
  endtask

  task automatic test_recycle();
    int cyc; bit saw; int nack;
    do_reset(cyc, saw);
    total++;
    if (cyc != 256) begin bad++; $display("FAIL recyc_init got=%0d want=256", cyc); end
    alpha = 4'b0111;
    nack = 0;
    for (int i = 0; i < 256; i++) begin
      enq_req = 1'b1; enq_qid = QW'(i % 32); enq_desc = 64'(i);
      @(negedge clk);
      if (enq_ack !== 1'b1) nack++;
    end
    total++;
    if (nack != 0) begin bad++; $display("FAIL recyc_fill not_acked=%0d want=0", nack); end
    enq_qid = 5'd1; enq_desc = 64'hEEE0;
    @(negedge clk);
    enq_req = 1'b0;
    total++;
    if (enq_drop !== 1'b1 || free_count !== '0) begin
      bad++; $display("FAIL recyc_full drop=%b free=%0d want 1/0", enq_drop, free_count);
    end
    deq_req = 1'b1; deq_qid = 5'd0;
    @(negedge clk);
    deq_req = 1'b0; enq_req = 1'b1; enq_qid = 5'd1; enq_desc = 64'hEEE1;
    total++;
    if (free_count !== '0) begin bad++; $display("FAIL recyc_free0 got=%0d want=0", free_count); end
    @(negedge clk);
    enq_desc = 64'hEEE2;
    total++;
    if (enq_drop !== 1'b1 || deq_ack !== 1'b1 || deq_desc !== 64'h0 || free_count !== 9'd1) begin
      bad++; $display("FAIL recyc_release drop=%b ack=%b desc=%h free=%0d want 1/1/0/1",
                      enq_drop, deq_ack, deq_desc, free_count);
    end
    @(negedge clk);
    enq_req = 1'b0;
    total++;
    if (enq_ack !== 1'b1 || free_count !== '0) begin
      bad++; $display("FAIL recyc_reuse ack=%b free=%0d want 1/0", enq_ack, free_count);
    end
  endtask

  task automatic test_reset_midflight();
    int cyc; bit saw;
    do_reset(cyc, saw);
    alpha = 4'd0;
    for (int i = 0; i < 10; i++) begin
      enq_req = 1'b1; enq_qid = 5'd2; enq_desc = 64'h2000 + 64'(i);
      @(negedge clk);
    end
    enq_req = 1'b0;
    deq_req = 1'b1; deq_qid = 5'd2;
    @(negedge clk);
    do_reset(cyc, saw);
    total++;
    if (saw !== 1'b0 || cyc != 256) begin
      bad++; $display("FAIL midrst saw_ack=%b init=%0d want 0/256", saw, cyc);
    end
    depth_qid = 5'd2;
    @(negedge clk);
    total++;
    if (depth !== '0 || free_count !== 9'd256) begin
      bad++; $display("FAIL midrst_state depth=%0d free=%0d want 0/256", depth, free_count);
    end
    deq_req = 1'b1; deq_qid = 5'd2;
    @(negedge clk); deq_req = 1'b0; @(negedge clk);
    total++;
    if (deq_empty !== 1'b1 || deq_ack !== 1'b0) begin
      bad++; $display("FAIL midrst_empty empty=%b ack=%b want 1/0", deq_empty, deq_ack);
    end
  endtask

  initial begin
    test_reset();
    test_fill_threshold();
    test_ordering();
    test_same_cycle();
    test_recycle();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
